// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory slice: word and RAM8 geometry
// and the RAM8 clear-engine state type.
package hack_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned RAM8_DEPTH  = 8;
    localparam int unsigned RAM8_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } ram8_state_t;

endpackage : hack_pkg

// File: rtl/ram8_clr_if.sv
// RAM8 access bus: write data, load strobe, word select and clear request
// from the CPU side; read data and clear-engine status back from the array.
interface ram8_clr_if #(
    parameter int unsigned WIDTH = hack_pkg::WORD_W
);
    import hack_pkg::*;

    logic [WIDTH-1:0]       in;
    logic                   load;
    logic [RAM8_ADDR_W-1:0] address;
    logic                   clear_req;
    logic [WIDTH-1:0]       out;
    logic                   busy;
    logic                   clear_done;

    modport master (
        output in, load, address, clear_req,
        input  out, busy, clear_done
    );

    modport slave (
        input  in, load, address, clear_req,
        output out, busy, clear_done
    );

endinterface : ram8_clr_if

// File: rtl/ram_word_reg.sv
// One register-file word: load-enabled register, async active-high reset to 0.
module ram_word_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on load; reset clears the word regardless of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : ram_word_reg

// File: rtl/ram8_clr.sv
// Hack RAM8 with a sequential clear engine. Eight word registers written by
// a one-hot decode of address; a clear request walks all eight words, one
// per cycle, writing CLEAR_VAL, then pulses clear_done.
// Optional macro RAM8_BYPASS_EN: write-through forwarding of `in` to `out`
// during an IDLE load.
module ram8_clr
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH     = WORD_W,
    parameter int unsigned CLEAR_VAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    ram8_clr_if.slave  bus
);

    localparam logic [WIDTH-1:0]       CLR_WORD = WIDTH'(CLEAR_VAL);
    localparam logic [RAM8_ADDR_W-1:0] LAST_IDX = RAM8_ADDR_W'(RAM8_DEPTH - 1);

    ram8_state_t            state_q, state_d;
    logic [RAM8_ADDR_W-1:0] cnt_q, cnt_d;

    logic [RAM8_DEPTH-1:0]  we;
    logic [WIDTH-1:0]       wdata;
    logic [WIDTH-1:0]       words [RAM8_DEPTH];
    logic [WIDTH-1:0]       rdata;

    // State register and clear counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus.busy       = 1'b0;
        bus.clear_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                bus.busy = 1'b1;
                // 3-bit counter wraps 7 -> 0 on the same edge that leaves CLEAR.
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.clear_done = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-word write enable: CPU load in IDLE, clear-engine pointer in CLEAR.
    always_comb begin
        we    = '0;
        wdata = (state_q == CLEAR) ? CLR_WORD : bus.in;
        for (int unsigned i = 0; i < RAM8_DEPTH; i++) begin
            if (state_q == IDLE) begin
                we[i] = bus.load && (bus.address == RAM8_ADDR_W'(i));
            end else if (state_q == CLEAR) begin
                we[i] = (cnt_q == RAM8_ADDR_W'(i));
            end
        end
    end

    for (genvar g = 0; g < RAM8_DEPTH; g++) begin : g_word
        ram_word_reg #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (we[g]),
            .d     (wdata),
            .q     (words[g])
        );
    end

    // Combinational read mux, optionally forwarding the IDLE write data.
    always_comb begin
        rdata = words[bus.address];
`ifdef RAM8_BYPASS_EN
        if ((state_q == IDLE) && bus.load) begin
            rdata = bus.in;
        end
`endif
        bus.out = rdata;
    end

endmodule : ram8_clr

// File: tb/tb_ram8_clr.sv
// Self-checking bench for ram8_clr: a driver issues directed and random
// cycles and pushes the reference model's expectation into a queue; a
// monitor pops and compares on every falling edge.
module tb_ram8_clr;

    localparam int unsigned W  = 16;
    localparam int unsigned CV = 32'h0000_C3A5;
    localparam logic [W-1:0] CVW = W'(CV);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ram8_clr_if #(.WIDTH(W)) bus ();

    ram8_clr #(
        .WIDTH     (W),
        .CLEAR_VAL (CV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         busy;
        logic         done;
        string        tag;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: memory contents plus a timeline position counted from
    // the edge that accepted a clear request (0 = no clear in progress,
    // 1..8 = clearing word p-1 at the end of this cycle, 9 = completion cycle).
    logic [W-1:0] mem [8];
    int           phase;

    // Inputs currently applied, so the model can replay them at the next edge.
    logic         a_rst, a_load, a_creq;
    logic [2:0]   a_addr;
    logic [W-1:0] a_in;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        phase = 0;
    endfunction

    function automatic void model_edge();
        if (a_rst) begin
            model_reset();
        end else if (phase == 0) begin
            if (a_load) mem[a_addr] = a_in;
            if (a_creq) phase = 1;
        end else if (phase <= 8) begin
            mem[phase - 1] = CVW;
            phase = phase + 1;
        end else begin
            phase = 0;
        end
    endfunction

    function automatic exp_t model_expect(input string tag);
        exp_t e;
        e.tag  = tag;
        if (a_rst) begin
            e.out  = '0;
            e.busy = 1'b0;
            e.done = 1'b0;
        end else begin
            e.out  = mem[a_addr];
`ifdef RAM8_BYPASS_EN
            if (phase == 0 && a_load) e.out = a_in;
`endif
            e.busy = (phase >= 1 && phase <= 8);
            e.done = (phase == 9);
        end
        return e;
    endfunction

    // One bus cycle: apply the edge to the model, drive new inputs just after
    // the rising edge (reset included, so it lands off-edge), queue expectation.
    task automatic cycle(input logic rst, input logic ld, input logic [2:0] ad,
                         input logic [W-1:0] din, input logic cr, input string tag);
        @(posedge clk);
        model_edge();
        #1;
        reset         = rst;
        bus.load      = ld;
        bus.address   = ad;
        bus.in        = din;
        bus.clear_req = cr;
        a_rst  = rst;
        a_load = ld;
        a_addr = ad;
        a_in   = din;
        a_creq = cr;
        if (rst) model_reset();
        exp_q.push_back(model_expect(tag));
    endtask

    task automatic idle(input logic [2:0] ad, input string tag);
        cycle(1'b0, 1'b0, ad, '0, 1'b0, tag);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, ".out"},  bus.out, e.out);
                check({e.tag, ".busy"}, W'(bus.busy), W'(e.busy));
                check({e.tag, ".done"}, W'(bus.clear_done), W'(e.done));
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_load = 1'b0; a_creq = 1'b0; a_addr = '0; a_in = '0;
        bus.load = 1'b0; bus.address = '0; bus.in = '0; bus.clear_req = 1'b0;
        model_reset();

        // Reset held, then released; sweep all addresses.
        cycle(1'b1, 1'b0, 3'd0, '0, 1'b0, "rst_hold");
        cycle(1'b1, 1'b1, 3'd5, 16'hFFFF, 1'b1, "rst_hold_in");
        for (int i = 0; i < 8; i++) idle(3'(i), "rst_sweep");

        // Write 0x1111*(i+1) to each word, read back; then disturb word 3 only.
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 3'(i), W'(16'h1111 * (i + 1)), 1'b0, "wr");
        for (int i = 0; i < 8; i++) idle(3'(i), "rd");
        cycle(1'b0, 1'b1, 3'd3, 16'h0F0F, 1'b0, "wr3");
        for (int i = 0; i < 8; i++) idle(3'(i), "rd_after_wr3");

        // Full-bank clear from all-ones.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), 16'hFFFF, 1'b0, "preload");
        cycle(1'b0, 1'b0, 3'd0, '0, 1'b1, "clr_req");
        for (int i = 0; i < 10; i++) idle(3'(i % 8), "clr_run");
        for (int i = 0; i < 8; i++) idle(3'(i), "clr_after");

        // Load during the third clear cycle is dropped.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), 16'h7777, 1'b0, "preload2");
        cycle(1'b0, 1'b0, 3'd7, '0, 1'b1, "clr_req2");
        idle(3'd7, "clr2_c1");
        idle(3'd7, "clr2_c2");
        cycle(1'b0, 1'b1, 3'd7, 16'hABCD, 1'b0, "clr2_ld");
        for (int i = 0; i < 8; i++) idle(3'd7, "clr2_tail");

        // Simultaneous load and clear request in IDLE.
        cycle(1'b0, 1'b1, 3'd2, 16'h5A5A, 1'b1, "ld_clr");
        idle(3'd2, "ld_clr_next");
        for (int i = 0; i < 9; i++) idle(3'd2, "ld_clr_run");
        idle(3'd2, "ld_clr_after");

        // clear_req held high: back-to-back clears on a 10-cycle period.
        for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 3'(i % 8), 16'h3C3C, 1'b1, "held_req");
        for (int i = 0; i < 12; i++) idle(3'(i % 8), "held_drain");

        // Async reset asserted off-edge in the fourth clear cycle.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'(i), 16'hBEEF, 1'b0, "preload3");
        cycle(1'b0, 1'b0, 3'd6, '0, 1'b1, "clr_req3");
        idle(3'd6, "clr3_c1");
        idle(3'd6, "clr3_c2");
        idle(3'd6, "clr3_c3");
        cycle(1'b1, 1'b0, 3'd6, '0, 1'b0, "mid_rst");
        cycle(1'b1, 1'b0, 3'd7, '0, 1'b0, "mid_rst_hold");
        for (int i = 0; i < 8; i++) idle(3'(i), "post_rst");

        // IDLE write followed by same-address read.
        cycle(1'b0, 1'b1, 3'd4, 16'h1234, 1'b0, "wr1234");
        idle(3'd4, "rd1234");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)), W'($urandom),
                  ($urandom_range(15) == 0), "rand");
        end
        for (int i = 0; i < 12; i++) idle(3'(i % 8), "rand_drain");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram8_clr
